// File: rtl/key_debounce_pkg.sv
// Shared constants and helpers for the push-button debounce front end.
// Keys are active-low at the pins and on the debounced level outputs.
package key_debounce_pkg;

  localparam logic KEY_ACTIVE = 1'b0;
  localparam logic KEY_IDLE   = 1'b1;

  // Counter width able to hold values 0..max_val-1, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, tick-sampled debounce counter,
// hold counter for the long-press event, and the registered event pulses.
module key_debounce_ch #(
  parameter int DEB_TICKS  = 20,
  parameter int HOLD_TICKS = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  input  logic sample_en,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);
  import key_debounce_pkg::*;

  localparam int DEB_W  = cnt_width(DEB_TICKS + 1);
  localparam int HOLD_W = cnt_width(HOLD_TICKS + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(HOLD_TICKS - 2);

  logic              sync1_r;
  logic              sync2_r;
  logic              level_r;
  logic              press_r;
  logic              release_r;
  logic              long_r;
  logic [DEB_W-1:0]  deb_cnt_r;
  logic [HOLD_W-1:0] hold_cnt_r;

  logic              level_nxt_s;
  logic              press_nxt_s;
  logic              release_nxt_s;
  logic              long_nxt_s;
  logic              accept_s;
  logic [DEB_W-1:0]  deb_cnt_nxt_s;
  logic [HOLD_W-1:0] hold_cnt_nxt_s;

  // Two-flop synchroniser for the asynchronous key pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= KEY_IDLE;
      sync2_r <= KEY_IDLE;
    end else begin
      sync1_r <= key_raw;
      sync2_r <= sync1_r;
    end
  end

  // Debounce decision: accept a new level after DEB_TICKS differing samples.
  always_comb begin
    level_nxt_s   = level_r;
    deb_cnt_nxt_s = deb_cnt_r;
    press_nxt_s   = 1'b0;
    release_nxt_s = 1'b0;
    accept_s      = 1'b0;
    if (sample_en) begin
      if (sync2_r != level_r) begin
        if (deb_cnt_r == DEB_LAST) begin
          accept_s      = 1'b1;
          level_nxt_s   = sync2_r;
          deb_cnt_nxt_s = '0;
          press_nxt_s   = (sync2_r == KEY_ACTIVE);
          release_nxt_s = (sync2_r != KEY_ACTIVE);
        end else begin
          deb_cnt_nxt_s = deb_cnt_r + DEB_W'(1);
        end
      end else begin
        deb_cnt_nxt_s = '0;
      end
    end else begin
      deb_cnt_nxt_s = deb_cnt_r;
    end
  end

  // Hold counter: the press tick is hold tick 0; saturates so long fires once.
  always_comb begin
    hold_cnt_nxt_s = hold_cnt_r;
    long_nxt_s     = 1'b0;
    if (sample_en) begin
      if ((level_r != KEY_ACTIVE) || accept_s) begin
        hold_cnt_nxt_s = '0;
      end else if (hold_cnt_r != HOLD_LAST) begin
        hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
        long_nxt_s     = (hold_cnt_r == HOLD_FIRE);
      end else begin
        hold_cnt_nxt_s = hold_cnt_r;
      end
    end else begin
      hold_cnt_nxt_s = hold_cnt_r;
    end
  end

  // Channel state and event pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_r    <= KEY_IDLE;
      press_r    <= 1'b0;
      release_r  <= 1'b0;
      long_r     <= 1'b0;
      deb_cnt_r  <= '0;
      hold_cnt_r <= '0;
    end else begin
      level_r    <= level_nxt_s;
      press_r    <= press_nxt_s;
      release_r  <= release_nxt_s;
      long_r     <= long_nxt_s;
      deb_cnt_r  <= deb_cnt_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
    end
  end

  assign key_level   = level_r;
  assign key_press   = press_r;
  assign key_release = release_r;
  assign key_long    = long_r;

endmodule

// File: rtl/key_debounce.sv
// Push-button front end: shared sample-tick prescaler feeding NKEY
// independent debounce channels with level, press, release and long outputs.
module key_debounce #(
  parameter int NKEY       = 4,
  parameter int CLK_DIV    = 50_000,
  parameter int DEB_TICKS  = 20,
  parameter int HOLD_TICKS = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NKEY-1:0] key_in,
  output logic [NKEY-1:0] key_level,
  output logic [NKEY-1:0] key_press,
  output logic [NKEY-1:0] key_release,
  output logic [NKEY-1:0] key_long,
  output logic            tick
);
  import key_debounce_pkg::*;

  localparam int DIV_W = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_r;
  logic [DIV_W-1:0] div_cnt_nxt_s;
  logic             tick_r;
  logic             tick_en_s;

  // Prescaler wrap; channels update on the same edge that raises tick.
  always_comb begin
    tick_en_s = (div_cnt_r == DIV_LAST);
    if (tick_en_s) begin
      div_cnt_nxt_s = '0;
    end else begin
      div_cnt_nxt_s = div_cnt_r + DIV_W'(1);
    end
  end

  // Prescaler counter and registered tick strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= '0;
      tick_r    <= 1'b0;
    end else begin
      div_cnt_r <= div_cnt_nxt_s;
      tick_r    <= tick_en_s;
    end
  end

  assign tick = tick_r;

  for (genvar g = 0; g < NKEY; g++) begin : g_ch
    key_debounce_ch #(
      .DEB_TICKS  (DEB_TICKS),
      .HOLD_TICKS (HOLD_TICKS)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .key_raw     (key_in[g]),
      .sample_en   (tick_en_s),
      .key_level   (key_level[g]),
      .key_press   (key_press[g]),
      .key_release (key_release[g]),
      .key_long    (key_long[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: a behavioural model built from sample
// histories and tick indices, compared against the DUT on every cycle.
module tb_key_debounce;

  localparam int NKEY       = 4;
  localparam int CLK_DIV    = 4;
  localparam int DEB_TICKS  = 3;
  localparam int HOLD_TICKS = 8;

  logic            clk;
  logic            rst;
  logic [NKEY-1:0] key_in;
  logic [NKEY-1:0] key_level;
  logic [NKEY-1:0] key_press;
  logic [NKEY-1:0] key_release;
  logic [NKEY-1:0] key_long;
  logic            tick;

  key_debounce #(
    .NKEY(NKEY), .CLK_DIV(CLK_DIV), .DEB_TICKS(DEB_TICKS), .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_level(key_level),
    .key_press(key_press), .key_release(key_release), .key_long(key_long), .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // ---------------- behavioural model ----------------
  logic [NKEY-1:0] pipe0, pipe1, sync_now;
  logic [NKEY-1:0] exp_level, exp_press, exp_release, exp_long;
  logic            exp_tick;
  logic [31:0]     hist [NKEY];
  int              seen [NKEY];
  int              press_tick [NKEY];
  int              cnt_press [NKEY];
  int              cnt_release [NKEY];
  int              cnt_long [NKEY];
  int              cnt_all_press = 0;
  int              cnt_all_release = 0;
  int              cyc = 0;
  int              tick_idx = 0;
  bit              model_valid = 1'b0;

  // True when the last DEB_TICKS samples all disagree with the current level.
  function automatic bit run_done(input logic [31:0] h, input int s, input logic lvl);
    logic [31:0] mask;
    mask = (32'd1 << DEB_TICKS) - 32'd1;
    if (s < DEB_TICKS) return 1'b0;
    return lvl ? ((h & mask) == 32'd0) : ((h & mask) == mask);
  endfunction

  initial begin
    for (int c = 0; c < NKEY; c++) begin
      cnt_press[c] = 0; cnt_release[c] = 0; cnt_long[c] = 0;
    end
  end

  always @(posedge clk) begin
    exp_press = '0; exp_release = '0; exp_long = '0; exp_tick = 1'b0;
    if (rst) begin
      pipe0 = '1; pipe1 = '1; cyc = 0; tick_idx = 0; exp_level = '1;
      for (int c = 0; c < NKEY; c++) begin
        hist[c] = 32'd0; seen[c] = 0; press_tick[c] = 0;
      end
      model_valid = 1'b1;
    end else begin
      sync_now = pipe1; pipe1 = pipe0; pipe0 = key_in;
      cyc = cyc + 1;
      if (cyc % CLK_DIV == 0) begin
        exp_tick = 1'b1;
        tick_idx = tick_idx + 1;
        for (int c = 0; c < NKEY; c++) begin
          hist[c] = {hist[c][30:0], sync_now[c]};
          seen[c] = seen[c] + 1;
          if (run_done(hist[c], seen[c], exp_level[c])) begin
            if (exp_level[c]) begin
              exp_press[c] = 1'b1; press_tick[c] = tick_idx; cnt_press[c]++;
            end else begin
              exp_release[c] = 1'b1; cnt_release[c]++;
            end
            exp_level[c] = ~exp_level[c];
          end else if (!exp_level[c] && (tick_idx - press_tick[c] == HOLD_TICKS - 1)) begin
            exp_long[c] = 1'b1; cnt_long[c]++;
          end
        end
        if (exp_press == '1) cnt_all_press++;
        if (exp_release == '1) cnt_all_release++;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      vectors++;
      if ({key_level, key_press, key_release, key_long, tick} !==
          {exp_level, exp_press, exp_release, exp_long, exp_tick}) begin
        errors++;
        $display("FAIL outputs t=%0t: level %b/%b press %b/%b release %b/%b long %b/%b tick %b/%b (got/want)",
                 $time, key_level, exp_level, key_press, exp_press, key_release, exp_release,
                 key_long, exp_long, tick, exp_tick);
      end
    end
  end

  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Release rst with all keys held low and pin the first tick and press timing.
  task automatic release_and_check(input string tag);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    pin({tag, "_no_tick_early"}, {31'd0, exp_tick}, 32'd0);
    @(negedge clk);
    pin({tag, "_first_tick"}, {31'd0, exp_tick}, 32'd1);
    pin({tag, "_dut_first_tick"}, {31'd0, tick}, 32'd1);
    pin({tag, "_no_press_t1"}, {28'd0, exp_press}, 32'd0);
    repeat (7) @(negedge clk);
    pin({tag, "_no_press_before_t3"}, {28'd0, exp_press}, 32'd0);
    pin({tag, "_level_before_t3"}, {28'd0, exp_level}, 32'hF);
    @(negedge clk);
    pin({tag, "_press_t3"}, {28'd0, exp_press}, 32'hF);
    pin({tag, "_dut_press_t3"}, {28'd0, key_press}, 32'hF);
    pin({tag, "_level_t3"}, {28'd0, exp_level}, 32'h0);
  endtask

  int b_p, b_r, b_l, b_ap, b_ar;
  int dur;
  logic [NKEY-1:0] flip_mask;

  initial begin
    // Scenario 1: reset with keys held, joint press on the third tick, long after 7 more.
    rst = 1'b1; key_in = '0;
    repeat (3) @(negedge clk);
    pin("rst_level", {28'd0, key_level}, 32'hF);
    pin("rst_pulses", {20'd0, key_press, key_release, key_long}, 32'd0);
    pin("rst_tick", {31'd0, tick}, 32'd0);
    release_and_check("s1");
    repeat (27) @(negedge clk);
    pin("s1_no_long_early", {28'd0, exp_long}, 32'd0);
    @(negedge clk);
    pin("s1_long", {28'd0, exp_long}, 32'hF);
    key_in = '1;
    repeat (40) @(negedge clk);

    // Scenario 2: clean press on key0 only.
    b_p = cnt_press[0]; b_ap = cnt_press[1] + cnt_press[2] + cnt_press[3];
    key_in[0] = 1'b0;
    repeat (40) @(negedge clk);
    pin("s2_press0", cnt_press[0] - b_p, 32'd1);
    pin("s2_others", cnt_press[1] + cnt_press[2] + cnt_press[3] - b_ap, 32'd0);
    pin("s2_level", {28'd0, exp_level}, 32'hE);
    key_in[0] = 1'b1;
    repeat (40) @(negedge clk);

    // Scenario 3: bounce on key1 is rejected, then a steady press is accepted.
    b_p = cnt_press[1]; b_r = cnt_release[1];
    for (int i = 0; i < 5; i++) begin
      key_in[1] = 1'b0; repeat (8) @(negedge clk);
      key_in[1] = 1'b1; repeat (4) @(negedge clk);
    end
    pin("s3_bounce_level", {31'd0, exp_level[1]}, 32'd1);
    pin("s3_bounce_pulses", cnt_press[1] - b_p + cnt_release[1] - b_r, 32'd0);
    key_in[1] = 1'b0;
    repeat (16) @(negedge clk);
    pin("s3_press1", cnt_press[1] - b_p, 32'd1);
    key_in[1] = 1'b1;
    repeat (40) @(negedge clk);

    // Scenario 4: long press on key2, once per hold.
    b_p = cnt_press[2]; b_r = cnt_release[2]; b_l = cnt_long[2];
    key_in[2] = 1'b0;
    repeat (80) @(negedge clk);
    pin("s4_press2", cnt_press[2] - b_p, 32'd1);
    pin("s4_long2_once", cnt_long[2] - b_l, 32'd1);
    key_in[2] = 1'b1;
    repeat (20) @(negedge clk);
    pin("s4_release2", cnt_release[2] - b_r, 32'd1);
    key_in[2] = 1'b0;
    repeat (60) @(negedge clk);
    pin("s4_long2_again", cnt_long[2] - b_l, 32'd2);
    key_in[2] = 1'b1;
    repeat (40) @(negedge clk);

    // Scenario 5: all keys pressed and released together.
    b_ap = cnt_all_press; b_ar = cnt_all_release;
    key_in = '0;
    repeat (20) @(negedge clk);
    pin("s5_all_press", cnt_all_press - b_ap, 32'd1);
    key_in = '1;
    repeat (20) @(negedge clk);
    pin("s5_all_release", cnt_all_release - b_ar, 32'd1);

    // Scenario 6: reset after two of three qualifying ticks.
    for (int i = 0; i < 8 && !exp_tick; i++) @(negedge clk);
    pin("s6_tick_align", {31'd0, exp_tick}, 32'd1);
    b_ap = cnt_press[0] + cnt_press[1] + cnt_press[2] + cnt_press[3];
    key_in = '0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    pin("s6_no_press", cnt_press[0] + cnt_press[1] + cnt_press[2] + cnt_press[3] - b_ap, 32'd0);
    pin("s6_level", {28'd0, exp_level}, 32'hF);
    release_and_check("s6");
    key_in = '1;
    repeat (40) @(negedge clk);

    // Random phase: steady segments of random length with occasional resets.
    for (int s = 0; s < 300; s++) begin
      dur = $urandom_range(1, 70);
      flip_mask = '0;
      for (int c = 0; c < NKEY; c++) flip_mask[c] = ($urandom_range(0, 3) == 0);
      key_in = key_in ^ flip_mask;
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst = 1'b0;
      end
      repeat (dur) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
